// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit (MIPS mult/div) with HI/LO registers.
// Multiply uses radix-2 Booth over 32 iterations, divide uses restoring
// division on operand magnitudes with sign correction on the final write.
module mult_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        mult_start,
   input  logic        div_start,
   input  logic [31:0] Data_A,
   input  logic [31:0] Data_B,
   output logic [31:0] HI_out,
   output logic [31:0] LO_out,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [5:0]  iter_cnt;

   // Shared working registers: A/Q/Q-1 for Booth, R/Q for division.
   logic [31:0] acc_a;
   logic [31:0] acc_q;
   logic        acc_q_m1;
   logic [31:0] opnd_m;     // multiplicand M, or divisor magnitude |B|
   logic        sign_q;
   logic        sign_r;

   logic        accept_mult;
   logic        accept_div;
   logic        reject_div;
   logic        last_iter;

   logic [31:0] abs_a;
   logic [31:0] abs_b;

   logic [32:0] booth_sum;
   logic [31:0] mult_a_nx;
   logic [31:0] mult_q_nx;

   logic [31:0] div_r_sh;
   logic [32:0] div_trial;
   logic [31:0] div_r_nx;
   logic [31:0] div_q_nx;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;

   // Operand magnitudes; negating -2^31 wraps back to 0x80000000, which is
   // exactly its unsigned magnitude.
   assign abs_a = Data_A[31] ? (32'd0 - Data_A) : Data_A;
   assign abs_b = Data_B[31] ? (32'd0 - Data_B) : Data_B;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic: only IDLE accepts work; both operations last 32 cycles.
   always_comb begin
      // NOTE: defaulting every always_comb output first prevents inferred latches.
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept_mult)     state_nx = MULT;
            else if (accept_div) state_nx = DIV;
         end
         MULT, DIV: begin
            if (last_iter) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Output/control decode; multiply wins when both starts arrive together.
   always_comb begin
      busy        = (state != IDLE);
      accept_mult = (state == IDLE) && mult_start;
      accept_div  = (state == IDLE) && !mult_start && div_start && (Data_B != 32'd0);
      reject_div  = (state == IDLE) && !mult_start && div_start && (Data_B == 32'd0);
      last_iter   = (state != IDLE) && (iter_cnt == 6'd31);
   end

   // One Booth step: add/subtract on a 33-bit sign-extended A, then shift the
   // whole {A, Q, Q-1} right arithmetically.
   always_comb begin
      booth_sum = {acc_a[31], acc_a};
      case ({acc_q[0], acc_q_m1})
         2'b01:   booth_sum = {acc_a[31], acc_a} + {opnd_m[31], opnd_m};
         2'b10:   booth_sum = {acc_a[31], acc_a} - {opnd_m[31], opnd_m};
         default: booth_sum = {acc_a[31], acc_a};
      endcase
      mult_a_nx = booth_sum[32:1];
      mult_q_nx = {booth_sum[0], acc_q[31:1]};
   end

   // One restoring-division step. R < |B| <= 2^31 keeps the shifted R in 32 bits.
   always_comb begin
      div_r_sh  = {acc_a[30:0], acc_q[31]};
      div_trial = {1'b0, div_r_sh} - {1'b0, opnd_m};
      if (div_trial[32]) begin
         div_r_nx = div_r_sh;
         div_q_nx = {acc_q[30:0], 1'b0};
      end else begin
         div_r_nx = div_trial[31:0];
         div_q_nx = {acc_q[30:0], 1'b1};
      end
      quot_fix = sign_q ? (32'd0 - div_q_nx) : div_q_nx;
      rem_fix  = sign_r ? (32'd0 - div_r_nx) : div_r_nx;
   end

   // Working registers: loaded on accept, stepped once per busy cycle.
   always_ff @(posedge clk) begin
      // NOTE: these are fully reloaded on every accept and never observed
      // outside an operation, so they need no reset.
      if (accept_mult) begin
         acc_a    <= 32'd0;
         acc_q    <= Data_B;
         acc_q_m1 <= 1'b0;
         opnd_m   <= Data_A;
      end else if (accept_div) begin
         acc_a    <= 32'd0;
         acc_q    <= abs_a;
         opnd_m   <= abs_b;
         sign_q   <= Data_A[31] ^ Data_B[31];
         sign_r   <= Data_A[31];
      end else if (state == MULT) begin
         acc_a    <= mult_a_nx;
         acc_q    <= mult_q_nx;
         acc_q_m1 <= acc_q[0];
      end else if (state == DIV) begin
         acc_a    <= div_r_nx;
         acc_q    <= div_q_nx;
      end
   end

   // Iteration counter, HI/LO result registers and completion pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         iter_cnt <= 6'd0;
         HI_out   <= 32'd0;
         LO_out   <= 32'd0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done     <= last_iter;
         div_zero <= reject_div;
         if (accept_mult || accept_div || last_iter) iter_cnt <= 6'd0;
         else if (busy)                              iter_cnt <= iter_cnt + 6'd1;
         if (last_iter) begin
            if (state == MULT) begin
               HI_out <= mult_a_nx;
               LO_out <= mult_q_nx;
            end else begin
               HI_out <= rem_fix;
               LO_out <= quot_fix;
            end
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO results,
// a monitor pops and compares them whenever done or div_zero pulses.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        mult_start;
   logic        div_start;
   logic [31:0] Data_A;
   logic [31:0] Data_B;
   logic [31:0] HI_out;
   logic [31:0] LO_out;
   logic        busy;
   logic        done;
   logic        div_zero;

   typedef struct {
      bit          is_dz;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t        sb_q[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] model_hi = 32'd0;
   logic [31:0] model_lo = 32'd0;
   int          busy_run = 0;

   mult_div_unit dut (
      .clk        (clk),
      .reset      (reset),
      .mult_start (mult_start),
      .div_start  (div_start),
      .Data_A     (Data_A),
      .Data_B     (Data_B),
      .HI_out     (HI_out),
      .LO_out     (LO_out),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (done || div_zero) begin
         check("pulse_exclusive", {done, div_zero}, (done ? 2'b10 : 2'b01));
         check("pulse_not_busy", busy, 1'b0);
         if (sb_q.size() == 0) begin
            check("unexpected_done", done, 1'b0);
            check("unexpected_div_zero", div_zero, 1'b0);
         end else begin
            e = sb_q.pop_front();
            check("pulse_kind", div_zero, e.is_dz);
            check("hi", HI_out, e.hi);
            check("lo", LO_out, e.lo);
            if (done) check("busy_cycles", busy_run, 32);
         end
      end
      if (busy) busy_run++;
      else      busy_run = 0;
   end

   // Issue one operation, push its expectation and wait for it to finish.
   // now=1 presents the start in the current (done) cycle for back-to-back use;
   // poke>0 pulses a stray div_start that many cycles into the operation.
   task automatic do_op(input bit is_div, input bit both,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo,
                        input bit now, input int poke);
      exp_t e;
      bit   finished;
      if (!now) @(negedge clk);
      if (is_div && !both && b == 32'd0) begin
         e = '{is_dz: 1'b1, hi: model_hi, lo: model_lo};
      end else begin
         e = '{is_dz: 1'b0, hi: hi, lo: lo};
         model_hi = hi;
         model_lo = lo;
      end
      sb_q.push_back(e);
      Data_A     = a;
      Data_B     = b;
      mult_start = !is_div || both;
      div_start  = is_div || both;
      @(negedge clk);
      mult_start = 1'b0;
      div_start  = 1'b0;
      finished   = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         if (!busy) begin
            finished = 1'b1;
            break;
         end
         if (i == poke) begin
            div_start = 1'b1;
            Data_A    = 32'h0000_0063;
            Data_B    = 32'h0000_0005;
         end else begin
            div_start = 1'b0;
         end
         @(negedge clk);
      end
      div_start = 1'b0;
      check("op_complete", finished, 1'b1);
   endtask

   initial begin
      reset      = 1'b1;
      mult_start = 1'b0;
      div_start  = 1'b0;
      Data_A     = 32'd0;
      Data_B     = 32'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_hi", HI_out, 32'd0);
      check("reset_lo", LO_out, 32'd0);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_div_zero", div_zero, 1'b0);

      // Multiplies: 7 * -3 = -21, (-2^31)^2 = 2^62
      do_op(1'b0, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0);
      do_op(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 0);

      // Divides: -7/2 = -3 r -1, overflow case, 100/-7 = -14 r 2
      do_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
      do_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 0);
      do_op(1'b1, 1'b0, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 0);

      // 5/0 presented in the done cycle of the previous divide: rejected,
      // HI/LO keep 2 / -14.
      do_op(1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'h0, 32'h0, 1'b1, 0);
      check("dz_hi_hold", HI_out, 32'h0000_0002);
      check("dz_lo_hold", LO_out, 32'hFFFF_FFF2);

      // Stray div_start at cycle 10 of a multiply: 0x12345678 * 16
      do_op(1'b0, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 10);

      // Back-to-back: multiply accepted in the done cycle. -5 * -5 = 25
      do_op(1'b0, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0019, 1'b1, 0);

      // Both starts in IDLE: multiply 6 * -2 = -12 (divide would give -3)
      do_op(1'b1, 1'b1, 32'h0000_0006, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0, 0);

      // Reset in the middle of a divide: no result is expected afterwards.
      @(negedge clk);
      Data_A    = 32'h0000_0064;
      Data_B    = 32'h0000_0007;
      div_start = 1'b1;
      @(negedge clk);
      div_start = 1'b0;
      repeat (14) @(negedge clk);
      check("busy_before_reset", busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_hi", HI_out, 32'd0);
      check("abort_lo", LO_out, 32'd0);
      model_hi = 32'd0;
      model_lo = 32'd0;
      repeat (40) @(negedge clk);
      check("abort_idle_hi", HI_out, 32'd0);
      check("abort_idle_lo", LO_out, 32'd0);

      check("scoreboard_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

endmodule
